// File: rtl/axis_sample_serializer.sv
// Serializes SAMP_PER_CLK complex samples per input beat into one sample per clock,
// and checks input tlast placement against the FFT_LEN frame length.
module axis_sample_serializer #(
    parameter int WIDTH        = 16,
    parameter int SAMP_PER_CLK = 4,
    parameter int FFT_LEN      = 16,
    parameter int ERR_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SAMP_PER_CLK*2*WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [2*WIDTH-1:0]              m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            frame_err,
    output logic [ERR_W-1:0]                err_count
);

    localparam int BEATS  = FFT_LEN / SAMP_PER_CLK;
    localparam int IDX_W  = (SAMP_PER_CLK > 1) ? $clog2(SAMP_PER_CLK) : 1;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SAMP_PER_CLK - 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    typedef logic [2*WIDTH-1:0] cx_t;

    cx_t [SAMP_PER_CLK-1:0] samp_buf_q, samp_buf_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   full_q, full_d;
    logic                   last_q, last_d;
    logic [BCNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                   frame_err_q, frame_err_d;
    logic [ERR_W-1:0]       err_count_q, err_count_d;

    logic in_accept;
    logic out_xfer;
    logic exp_last;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // tready depends only on registered state, m_axis_tready and rst, never on s_axis_tvalid
    assign s_axis_tready = ~rst & (~full_q | ((idx_q == LAST_IDX) & m_axis_tready));
    assign in_accept     = s_axis_tvalid & s_axis_tready;
    assign out_xfer      = full_q & m_axis_tready;
    assign exp_last      = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        samp_buf_d  = samp_buf_q;
        idx_d       = idx_q;
        full_d      = full_q;
        last_d      = last_q;
        beat_cnt_d  = beat_cnt_q;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;

        if (out_xfer) begin
            if (idx_q != LAST_IDX) begin
                idx_d = IDX_W'(idx_q + 1'b1);
            end else begin
                full_d = 1'b0;
            end
        end

        // A new beat overrides the drain of the previous one in the same cycle
        if (in_accept) begin
            samp_buf_d  = s_axis_tdata;
            last_d      = s_axis_tlast;
            full_d      = 1'b1;
            idx_d       = '0;
            frame_err_d = (s_axis_tlast != exp_last);
            if (frame_err_d) begin
                err_count_d = sat_inc(err_count_q);
            end
            if (s_axis_tlast || exp_last) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = BCNT_W'(beat_cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_buf_q  <= '0;
            idx_q       <= '0;
            full_q      <= 1'b0;
            last_q      <= 1'b0;
            beat_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            samp_buf_q  <= samp_buf_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_axis_tdata  = samp_buf_q[idx_q];
    assign m_axis_tvalid = full_q;
    assign m_axis_tlast  = full_q & last_q & (idx_q == LAST_IDX);
    assign frame_err     = frame_err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_axis_sample_serializer.sv
// Directed bench for axis_sample_serializer: a 4-lane instance (ERR_W=2) and a 1-lane instance.
module tb_axis_sample_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4 lanes per beat, 16-sample frames, 2-bit error counter
    logic [127:0] s4_tdata;
    logic         s4_tvalid, s4_tlast, s4_tready;
    logic [31:0]  m4_tdata;
    logic         m4_tvalid, m4_tlast, m4_tready;
    logic         ferr4;
    logic [1:0]   ecnt4;

    // 1 lane per beat, 16-sample frames
    logic [31:0]  s1_tdata;
    logic         s1_tvalid, s1_tlast, s1_tready;
    logic [31:0]  m1_tdata;
    logic         m1_tvalid, m1_tlast, m1_tready;
    logic         ferr1;
    logic [15:0]  ecnt1;

    axis_sample_serializer #(.WIDTH(16), .SAMP_PER_CLK(4), .FFT_LEN(16), .ERR_W(2)) dut4 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s4_tdata), .s_axis_tvalid(s4_tvalid), .s_axis_tlast(s4_tlast),
        .s_axis_tready(s4_tready),
        .m_axis_tdata(m4_tdata), .m_axis_tvalid(m4_tvalid), .m_axis_tlast(m4_tlast),
        .m_axis_tready(m4_tready),
        .frame_err(ferr4), .err_count(ecnt4)
    );

    axis_sample_serializer #(.WIDTH(16), .SAMP_PER_CLK(1), .FFT_LEN(16), .ERR_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tlast(s1_tlast),
        .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast),
        .m_axis_tready(m1_tready),
        .frame_err(ferr1), .err_count(ecnt1)
    );

    int checks = 0;
    int errors = 0;

    // Results collected by the 4-lane stream driver
    logic [15:0] out_re [64];
    logic [15:0] out_im [64];
    logic        out_last [64];
    int          out_cyc [64];
    logic [1:0]  ecnt_at [8];
    int nout, stable_viol, rdy_viol, vld_viol, ferr_cnt, ferr_acc0;

    // Lane j of a beat: re = base+j, im = base+j+0x100
    function automatic logic [127:0] mkbeat(input int base);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) begin
            v[j*32 +: 32] = {16'(base + j + 'h100), 16'(base + j)};
        end
        return v;
    endfunction

    function automatic logic [31:0] mk1(input int t);
        return {16'(t + 'h100), 16'(t)};
    endfunction

    // Drives nbeats beats (tlast where lbits is set) and records what comes out;
    // tracks an outstanding-sample model of tvalid/tready and hold stability.
    task automatic run4(input int nbeats, input int base, input logic [31:0] lbits, input bit bp);
        int b, acc, cyc, outst;
        bit exp_rdy, do_acc, do_out, hold;
        logic [31:0] held;
        b = 0; acc = 0; cyc = 0; nout = 0;
        stable_viol = 0; rdy_viol = 0; vld_viol = 0; ferr_cnt = 0; ferr_acc0 = -1;
        hold = 1'b0; held = '0;
        while (!(b == nbeats && nout == acc * 4) && cyc < 400) begin
            s4_tvalid = (b < nbeats);
            s4_tdata  = mkbeat(base + b * 4);
            s4_tlast  = (b < nbeats) ? lbits[b[4:0]] : 1'b0;
            m4_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            outst = acc * 4 - nout;
            if (m4_tvalid !== (outst > 0)) vld_viol++;
            exp_rdy = (outst == 0) || (outst == 1 && m4_tready);
            if (s4_tready !== exp_rdy) rdy_viol++;
            if (hold && (m4_tvalid !== 1'b1 || m4_tdata !== held)) stable_viol++;
            if (ferr4 === 1'b1) begin
                if (ferr_cnt == 0) ferr_acc0 = acc;
                if (ferr_cnt < 8) ecnt_at[ferr_cnt] = ecnt4;
                ferr_cnt++;
            end
            do_acc = s4_tvalid && (s4_tready === 1'b1);
            do_out = (m4_tvalid === 1'b1) && m4_tready;
            if (do_out && nout < 64) begin
                out_re[nout]   = m4_tdata[15:0];
                out_im[nout]   = m4_tdata[31:16];
                out_last[nout] = m4_tlast;
                out_cyc[nout]  = cyc;
            end
            if (do_out) nout++;
            hold = (m4_tvalid === 1'b1) && !m4_tready;
            held = m4_tdata;
            @(posedge clk); #1;
            if (do_acc) begin acc++; b++; end
            cyc++;
        end
        s4_tvalid = 1'b0;
        s4_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s4_tvalid = 0; s4_tlast = 0; s4_tdata = '0; m4_tready = 1;
        s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0; m1_tready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m4_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m4_tvalid got %b want 0", m4_tvalid); end
        checks++; if (m4_tdata !== 32'h0) begin errors++; $display("FAIL rst_m4_tdata got %h want 0", m4_tdata); end
        checks++; if (m4_tlast !== 1'b0) begin errors++; $display("FAIL rst_m4_tlast got %b want 0", m4_tlast); end
        checks++; if (s4_tready !== 1'b0) begin errors++; $display("FAIL rst_s4_tready got %b want 0", s4_tready); end
        checks++; if (ferr4 !== 1'b0 || ecnt4 !== 2'd0) begin errors++; $display("FAIL rst_err4 got %b/%0d want 0/0", ferr4, ecnt4); end
        checks++; if (m1_tvalid !== 1'b0 || m1_tdata !== 32'h0) begin errors++; $display("FAIL rst_m1 got %b/%h want 0/0", m1_tvalid, m1_tdata); end
        checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL rst_s1_tready got %b want 0", s1_tready); end
        rst = 1'b0;
        #1;
        checks++; if (s4_tready !== 1'b1) begin errors++; $display("FAIL post_rst_s4_tready got %b want 1", s4_tready); end
        checks++; if (s1_tready !== 1'b1) begin errors++; $display("FAIL post_rst_s1_tready got %b want 1", s1_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        run4(8, 0, 32'h88, 1'b0);
        checks++; if (nout !== 32) begin errors++; $display("FAIL ramp_count got %0d want 32", nout); end
        for (int k = 0; k < 32 && k < nout; k++) begin
            checks++; if (out_re[k] !== 16'(k)) begin errors++; $display("FAIL ramp_re[%0d] got %0d want %0d", k, out_re[k], k); end
            checks++; if (out_im[k] !== 16'(k + 'h100)) begin errors++; $display("FAIL ramp_im[%0d] got %h want %h", k, out_im[k], 16'(k + 'h100)); end
            checks++; if (out_last[k] !== (k == 15 || k == 31)) begin errors++; $display("FAIL ramp_tlast[%0d] got %b want %b", k, out_last[k], (k == 15 || k == 31)); end
            checks++; if (out_cyc[k] !== out_cyc[0] + k) begin errors++; $display("FAIL ramp_bubble[%0d] got cyc %0d want %0d", k, out_cyc[k], out_cyc[0] + k); end
        end
        checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL ramp_s_tready got %0d bad cycles want 0", rdy_viol); end
        checks++; if (vld_viol !== 0) begin errors++; $display("FAIL ramp_m_tvalid got %0d bad cycles want 0", vld_viol); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL ramp_frame_err got %0d pulses want 0", ferr_cnt); end
    endtask

    task automatic test_backpressure();
        run4(4, 0, 32'h8, 1'b1);
        checks++; if (nout !== 16) begin errors++; $display("FAIL bp_count got %0d want 16", nout); end
        for (int k = 0; k < 16 && k < nout; k++) begin
            checks++; if (out_re[k] !== 16'(k)) begin errors++; $display("FAIL bp_re[%0d] got %0d want %0d", k, out_re[k], k); end
            checks++; if (out_last[k] !== (k == 15)) begin errors++; $display("FAIL bp_tlast[%0d] got %b want %b", k, out_last[k], (k == 15)); end
        end
        checks++; if (stable_viol !== 0) begin errors++; $display("FAIL bp_hold_stable got %0d bad cycles want 0", stable_viol); end
        checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL bp_s_tready got %0d bad cycles want 0", rdy_viol); end
        checks++; if (vld_viol !== 0) begin errors++; $display("FAIL bp_m_tvalid got %0d bad cycles want 0", vld_viol); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL bp_frame_err got %0d pulses want 0", ferr_cnt); end
    endtask

    task automatic test_misplaced_tlast();
        // tlast on beat 1 (bad), then two correct frames ending on beats 5 and 9
        run4(10, 64, 32'h222, 1'b0);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL mis_err_pulses got %0d want 1", ferr_cnt); end
        checks++; if (ferr_acc0 !== 2) begin errors++; $display("FAIL mis_err_position got beat count %0d want 2", ferr_acc0); end
        checks++; if (ecnt4 !== 2'd1) begin errors++; $display("FAIL mis_err_count got %0d want 1", ecnt4); end
        checks++; if (nout !== 40) begin errors++; $display("FAIL mis_count got %0d want 40", nout); end
        for (int k = 0; k < 40 && k < nout; k++) begin
            checks++; if (out_last[k] !== (k == 7 || k == 23 || k == 39)) begin errors++; $display("FAIL mis_tlast[%0d] got %b want %b", k, out_last[k], (k == 7 || k == 23 || k == 39)); end
            checks++; if (out_re[k] !== 16'(64 + k)) begin errors++; $display("FAIL mis_re[%0d] got %0d want %0d", k, out_re[k], 64 + k); end
        end
    endtask

    task automatic test_reset_mid_frame();
        s4_tvalid = 1; s4_tdata = mkbeat(100); s4_tlast = 0; m4_tready = 1;
        #1;
        checks++; if (s4_tready !== 1'b1) begin errors++; $display("FAIL rmf_ready_empty got %b want 1", s4_tready); end
        @(posedge clk); #1;
        s4_tvalid = 0;
        #1;
        checks++; if (m4_tvalid !== 1'b1 || m4_tdata[15:0] !== 16'd100) begin errors++; $display("FAIL rmf_lane0 got %b/%0d want 1/100", m4_tvalid, m4_tdata[15:0]); end
        @(posedge clk); #2;
        checks++; if (m4_tdata[15:0] !== 16'd101) begin errors++; $display("FAIL rmf_lane1 got %0d want 101", m4_tdata[15:0]); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (s4_tready !== 1'b0) begin errors++; $display("FAIL rmf_ready_in_rst got %b want 0", s4_tready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (m4_tvalid !== 1'b0) begin errors++; $display("FAIL rmf_tvalid got %b want 0", m4_tvalid); end
        checks++; if (m4_tdata !== 32'h0) begin errors++; $display("FAIL rmf_tdata got %h want 0", m4_tdata); end
        checks++; if (m4_tlast !== 1'b0) begin errors++; $display("FAIL rmf_tlast got %b want 0", m4_tlast); end
        checks++; if (ecnt4 !== 2'd0) begin errors++; $display("FAIL rmf_err_count got %0d want 0", ecnt4); end
        @(posedge clk); #1;
        run4(4, 200, 32'h8, 1'b0);
        checks++; if (nout !== 16) begin errors++; $display("FAIL rmf_count got %0d want 16", nout); end
        checks++; if (out_re[0] !== 16'd200) begin errors++; $display("FAIL rmf_first_lane got %0d want 200", out_re[0]); end
        checks++; if (out_re[15] !== 16'd215) begin errors++; $display("FAIL rmf_last_lane got %0d want 215", out_re[15]); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL rmf_frame_err got %0d pulses want 0", ferr_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        // five 2-beat frames, each with tlast on its second beat
        run4(10, 300, 32'h2AA, 1'b0);
        checks++; if (ferr_cnt !== 5) begin errors++; $display("FAIL sat_pulses got %0d want 5", ferr_cnt); end
        for (int i = 0; i < 5 && i < ferr_cnt; i++) begin
            checks++; if (ecnt_at[i] !== sat_exp[i]) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, ecnt_at[i], sat_exp[i]); end
        end
        checks++; if (ecnt4 !== 2'd3) begin errors++; $display("FAIL sat_final got %0d want 3", ecnt4); end
        checks++; if (nout !== 40 || out_re[39] !== 16'd339) begin errors++; $display("FAIL sat_data got %0d/%0d want 40/339", nout, out_re[39]); end
    endtask

    task automatic test_single_lane();
        for (int t = 0; t <= 20; t++) begin
            s1_tvalid = (t < 20); s1_tdata = mk1(t); s1_tlast = (t == 15); m1_tready = 1;
            #1;
            if (t == 0) begin
                checks++; if (m1_tvalid !== 1'b0) begin errors++; $display("FAIL sl_first_tvalid got %b want 0", m1_tvalid); end
            end else begin
                checks++; if (m1_tvalid !== 1'b1) begin errors++; $display("FAIL sl_tvalid[%0d] got %b want 1", t, m1_tvalid); end
                checks++; if (m1_tdata !== mk1(t - 1)) begin errors++; $display("FAIL sl_tdata[%0d] got %h want %h", t, m1_tdata, mk1(t - 1)); end
                checks++; if (m1_tlast !== (t == 16)) begin errors++; $display("FAIL sl_tlast[%0d] got %b want %b", t, m1_tlast, (t == 16)); end
                checks++; if (ferr1 !== 1'b0) begin errors++; $display("FAIL sl_frame_err[%0d] got %b want 0", t, ferr1); end
            end
            checks++; if (s1_tready !== 1'b1) begin errors++; $display("FAIL sl_tready[%0d] got %b want 1", t, s1_tready); end
            @(posedge clk); #1;
        end
        // stall the output with one sample held and another waiting
        s1_tvalid = 1; s1_tdata = mk1(50); s1_tlast = 0; m1_tready = 0;
        #1;
        checks++; if (s1_tready !== 1'b1) begin errors++; $display("FAIL sl_bp_empty_ready got %b want 1", s1_tready); end
        @(posedge clk); #1;
        s1_tdata = mk1(51);
        #1;
        checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL sl_bp_ready got %b want 0", s1_tready); end
        checks++; if (m1_tdata !== mk1(50) || m1_tvalid !== 1'b1) begin errors++; $display("FAIL sl_bp_hold got %b/%h want 1/%h", m1_tvalid, m1_tdata, mk1(50)); end
        @(posedge clk); #1;
        m1_tready = 1;
        #1;
        checks++; if (s1_tready !== 1'b1) begin errors++; $display("FAIL sl_bp_release_ready got %b want 1", s1_tready); end
        checks++; if (m1_tdata !== mk1(50)) begin errors++; $display("FAIL sl_bp_stable got %h want %h", m1_tdata, mk1(50)); end
        @(posedge clk); #1;
        s1_tvalid = 0;
        #1;
        checks++; if (m1_tdata !== mk1(51) || m1_tvalid !== 1'b1) begin errors++; $display("FAIL sl_bp_next got %b/%h want 1/%h", m1_tvalid, m1_tdata, mk1(51)); end
        @(posedge clk); #1;
        checks++; if (m1_tvalid !== 1'b0) begin errors++; $display("FAIL sl_drain got %b want 0", m1_tvalid); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_misplaced_tlast();
        test_reset_mid_frame();
        test_saturation();
        test_single_lane();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
